sort8_stream_bridge: RTL
========================

Name: sort8_stream_bridge

Overview:
- Clocked front/back end for the asynchronous 8-entry sorter `sort8`: 4-phase req/fin, bundled data, 128-bit packed bus.
- Collects 8 words from a valid/ready input stream and packs them onto the sorter input bus.
- Runs one full 4-phase handshake with the sorter, captures the sorted bus, then streams the 8 results out in order with a last marker.
- Sits between the synchronous datapath and the `sort8` instance; it is the only clocked agent that drives `sort8.req`.

Parameters:
- W, 16, word width; must match the sorter word width.
- N, 8, words per batch; fixed at 8 for `sort8`; packed bus width is N*W.
- SYNC_STAGES, 2, flops in the fin synchronizer; minimum 2.
- SETUP_CYCLES, 1, clock cycles the packed input is held stable before req rises (bundled-data setup margin).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input word valid
- in_ready  out  1  bridge accepts an input word
- in_data  in  W  input word
- out_valid  out  1  sorted word valid
- out_ready  in  1  downstream accepts a sorted word
- out_data  out  W  sorted word
- out_last  out  1  high with the 8th sorted word of a batch
- sort_req  out  1  4-phase request to sorter; driven from a flop, glitch-free
- sort_fin  in  1  4-phase acknowledge from sorter; asynchronous, synchronized internally
- sort_din  out  N*W  packed sorter input
- sort_dout  in  N*W  packed sorter output; valid while sort_fin is high
- busy  out  1  high in any state except LOAD with count 0

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: sort_req=0, in_ready=0, out_valid=0, out_last=0, out_data=0, sort_din=0, busy=1.
  - Word count=0; state=RTZ_INIT; synchronizer flops=0.
- Packing: the k-th accepted word (k=0..7) occupies sort_din[(N-1-k)*W +: W], so word 0 sits in the MSBs. Unpacking uses the same rule: sorted word k comes from sort_dout[(N-1-k)*W +: W] and is emitted k-th.
- fin_s is sort_fin passed through SYNC_STAGES flops. All handshake decisions use fin_s only.
- States:
  - RTZ_INIT: in_ready=0. Go to LOAD when fin_s==0. This covers reset during an active sort: the sorter must return to zero before a new req is issued.
  - LOAD: in_ready=1. On in_valid&in_ready, write the word into its sort_din slot and increment the count. When the 8th word is accepted, go to SETUP; the SETUP counter starts at 0. busy=0 only when count==0.
  - SETUP: in_ready=0; sort_din frozen. After SETUP_CYCLES cycles, set sort_req=1 and go to WAIT_ACK.
  - WAIT_ACK: hold sort_req=1 and sort_din. When fin_s==1, capture sort_dout into the N-entry result register, clear sort_req to 0, and go to WAIT_RTZ.
  - WAIT_RTZ: when fin_s==0, go to DRAIN with index 0. sort_din stays stable until this exit.
  - DRAIN:
    - out_valid=1, out_data=result[index], out_last=(index==N-1). These are registered outputs, updated on the transfer edge.
    - On out_valid&out_ready, increment index. After the transfer with out_last, out_valid=0, count=0, and go to LOAD.
    - out_ready low holds out_data and out_last stable indefinitely.
- Latency, batch-complete to first output:
  - minimum = SETUP_CYCLES + 1 (req) + SYNC_STAGES (fin rise) + 1 (capture) + SYNC_STAGES (fin fall) + 1 cycles;
  - plus the sorter's own delays.
- No overlap: input and output never transfer in the same cycle.
- in_valid held high across the batch boundary is not accepted until LOAD is re-entered.
- sort_fin rising while sort_req==0, or outside WAIT_ACK: ignored, and never causes a capture.
- sort_fin glitches shorter than one clock may be filtered or delayed, but never produce two captures per batch.
- Reset mid-DRAIN: result discarded; out_valid drops asynchronously.

Decomposition:
- Shared package: state encoding (RTZ_INIT, LOAD, SETUP, WAIT_ACK, WAIT_RTZ, DRAIN), default W/N, and the slot-index function (N-1-k).
- One sub-module: async_bit_sync (parameter SYNC_STAGES; ports clk, rst_n, d, q). Reused for any future async handshake inputs.

Test Plan:
- Reset with sort_fin=0, then feed 0x0005,0x0003,0x0008,0x0001,0x0007,0x0002,0x0006,0x0004 → sort_din=0x0005_0003_0008_0001_0007_0002_0006_0004; sort_req rises exactly SETUP_CYCLES cycles after the 8th accept.
- Behavioural sorter model (fin rises 40 ns after req, dout = ascending) → out stream 0x0001..0x0008 in order, out_last only on 0x0008; sort_req falls before fin falls.
- out_ready toggling 1,0,0,1 during DRAIN → no word lost or duplicated; out_data stable while stalled.
- Hold sort_fin=1 across reset release → in_ready stays 0 until fin low + SYNC_STAGES cycles, then becomes 1.
- Spurious sort_fin pulse (3 cycles) during LOAD → no capture, no state change; normal batch after it sorts correctly.
- Back-to-back batches with in_valid constantly 1 (batch 2 = 0xFFFF..0xFFF8) → 16 outputs, two out_last pulses, in_ready 0 throughout DRAIN.

Source files
------------

// File: rtl/sort8_stream_bridge_pkg.sv
// Shared definitions for the sort8 stream bridge: the control state encoding,
// the default geometry and the word-slot mapping of the packed sorter buses.
`timescale 1ns/1ps
package sort8_stream_bridge_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_N = 8;

    typedef enum logic [2:0] {
        RTZ_INIT = 3'd0,
        LOAD     = 3'd1,
        SETUP    = 3'd2,
        WAIT_ACK = 3'd3,
        WAIT_RTZ = 3'd4,
        DRAIN    = 3'd5
    } state_e;

    // Word k of a batch lives in slot N-1-k of the packed bus, so word 0 sits in the MSBs.
    function automatic int slot_idx(input int k, input int n);
        return n - 1 - k;
    endfunction

endpackage

// File: rtl/sort8_stream_bridge_async_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous level (handshake inputs).
`timescale 1ns/1ps
module async_bit_sync
    import sort8_stream_bridge_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the asynchronous level through the flop chain; the chain clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/sort8_stream_bridge.sv
// Clocked bridge around the asynchronous sort8 network: gathers N words from a
// valid/ready stream, runs one 4-phase req/fin handshake with bundled data,
// then streams the sorted words out with a last marker.
`timescale 1ns/1ps
module sort8_stream_bridge
    import sort8_stream_bridge_pkg::*;
#(
    parameter int W            = DEF_W,
    parameter int N            = DEF_N,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    output logic           sort_req,
    input  logic           sort_fin,
    output logic [N*W-1:0] sort_din,
    input  logic [N*W-1:0] sort_dout,
    output logic           busy
);

    localparam int CW  = $clog2(N + 1);
    localparam int IW  = $clog2(N);
    localparam int SCW = $clog2(SETUP_CYCLES + 1);
    localparam int RCW = $clog2(SYNC_STAGES + 1);

    state_e          state_q;
    state_e          state_d;
    logic            fin_s;
    logic [CW-1:0]   count_q;
    logic [SCW-1:0]  setup_cnt_q;
    logic [RCW-1:0]  rtz_cnt_q;
    logic            req_q;
    logic [N*W-1:0]  din_q;
    logic [W-1:0]    result_q [N];
    logic [W-1:0]    dout_words [N];
    logic [IW-1:0]   idx_q;
    logic [IW-1:0]   idx_next;
    logic            out_valid_q;
    logic            out_last_q;
    logic [W-1:0]    out_data_q;

    logic accept;
    logic last_accept;
    logic rtz_settled;
    logic setup_done;
    logic out_fire;
    logic drain_done;
    logic capture;
    logic drain_start;

    async_bit_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_fin_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sort_fin),
        .q    (fin_s)
    );

    // Unpack the sorter output with the same slot rule used for packing.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign dout_words[gi] = sort_dout[slot_idx(gi, N)*W +: W];
    end

    assign accept      = (state_q == LOAD) && in_valid;
    assign last_accept = accept && (count_q == CW'(N - 1));
    // The synchronizer resets to 0, so fin_s is only trusted once the chain has refilled.
    assign rtz_settled = (rtz_cnt_q == RCW'(SYNC_STAGES));
    assign setup_done  = (setup_cnt_q == SCW'(SETUP_CYCLES - 1));
    assign out_fire    = out_valid_q && out_ready;
    assign drain_done  = out_fire && out_last_q;
    assign capture     = (state_q == WAIT_ACK) && fin_s;
    assign drain_start = (state_q == WAIT_RTZ) && !fin_s;
    assign idx_next    = idx_q + IW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RTZ_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; every handshake decision looks at the synchronized fin only.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RTZ_INIT: if (rtz_settled && !fin_s) state_d = LOAD;
            LOAD:     if (last_accept)           state_d = SETUP;
            SETUP:    if (setup_done)            state_d = WAIT_ACK;
            WAIT_ACK: if (fin_s)                 state_d = WAIT_RTZ;
            WAIT_RTZ: if (!fin_s)                state_d = DRAIN;
            DRAIN:    if (drain_done)            state_d = LOAD;
            default:                             state_d = RTZ_INIT;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        in_ready = (state_q == LOAD);
        busy     = !((state_q == LOAD) && (count_q == '0));
    end

    // Settle counter for the fin synchronizer, word counter and SETUP timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rtz_cnt_q   <= '0;
            count_q     <= '0;
            setup_cnt_q <= '0;
        end else begin
            if ((state_q == RTZ_INIT) && !rtz_settled) begin
                rtz_cnt_q <= rtz_cnt_q + RCW'(1);
            end
            if (accept) begin
                count_q <= count_q + CW'(1);
            end else if (drain_done) begin
                count_q <= '0;
            end
            if (last_accept) begin
                setup_cnt_q <= '0;
            end else if (state_q == SETUP) begin
                setup_cnt_q <= setup_cnt_q + SCW'(1);
            end
        end
    end

    // Request flop: rises after the setup margin, returns to zero once fin is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= 1'b0;
        end else if ((state_q == SETUP) && setup_done) begin
            req_q <= 1'b1;
        end else if (capture) begin
            req_q <= 1'b0;
        end
    end

    // Packed sorter input: only written in LOAD, so it stays frozen through the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (accept && (count_q == CW'(k))) begin
                    din_q[slot_idx(k, N)*W +: W] <= in_data;
                end
            end
        end
    end

    // Result register: a single capture per batch, only in WAIT_ACK with req high.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N; k++) begin
                result_q[k] <= dout_words[k];
            end
        end
    end

    // Registered output stage: loaded on DRAIN entry, advanced on each transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            idx_q       <= '0;
        end else if (drain_start) begin
            out_valid_q <= 1'b1;
            out_data_q  <= result_q[0];
            out_last_q  <= (N == 1);
            idx_q       <= '0;
        end else if (out_fire) begin
            if (out_last_q) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end else begin
                idx_q      <= idx_next;
                out_data_q <= result_q[idx_next];
                out_last_q <= (idx_next == IW'(N - 1));
            end
        end
    end

    assign sort_req  = req_q;
    assign sort_din  = din_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign out_data  = out_data_q;

endmodule
